// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_arbiter.
// The arbiter connects through the master modport; the surrounding environment uses slave.
interface mem_arbiter_if #(
    parameter int ADDR_LENGTH = 10,
    parameter int BLOCK_SIZE  = 32
);
    logic [1:0]             req;
    logic [1:0]             req_we;
    logic [ADDR_LENGTH-1:0] req_addr0;
    logic [ADDR_LENGTH-1:0] req_addr1;
    logic [BLOCK_SIZE-1:0]  req_wdata0;
    logic [BLOCK_SIZE-1:0]  req_wdata1;
    logic [1:0]             ack;
    logic [BLOCK_SIZE-1:0]  rdata;
    logic                   err;
    logic                   busy;
    logic                   mem_enable;
    logic                   mem_we;
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic [BLOCK_SIZE-1:0]  mem_data_in;
    logic [BLOCK_SIZE-1:0]  mem_data_out;
    logic                   mem_complete;

    modport master (
        input  req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_data_out, mem_complete,
        output ack, rdata, err, busy,
        output mem_enable, mem_we, mem_addr, mem_data_in
    );

    modport slave (
        output req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output mem_data_out, mem_complete,
        input  ack, rdata, err, busy,
        input  mem_enable, mem_we, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a fixed-latency main memory.
// Define MEM_ARB_TIMEOUT_EN to enable the WAIT-state watchdog that reports err with ack.
module mem_arbiter #(
    parameter int ADDR_LENGTH    = 10,
    parameter int BLOCK_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]             state_q,      state_d;
    logic                   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       wait_cnt_q,   wait_cnt_d;
    logic                   mem_enable_q, mem_enable_d;
    logic                   mem_we_q,     mem_we_d;
    logic [ADDR_LENGTH-1:0] mem_addr_q,   mem_addr_d;
    logic [BLOCK_SIZE-1:0]  mem_wdata_q,  mem_wdata_d;
    logic [1:0]             ack_q,        ack_d;
    logic [BLOCK_SIZE-1:0]  rdata_q,      rdata_d;
    logic                   err_q,        err_d;
    logic                   busy_q,       busy_d;

    logic other;
    logic winner;
    logic accept;

    always_comb begin
        other  = ~last_grant_q;
        winner = bus.req[other] ? other : last_grant_q;
        // A complete flag seen in the first WAIT cycle belongs to the previous access.
        accept = bus.mem_complete && (wait_cnt_q != '0);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        mem_enable_d = mem_enable_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    last_grant_d = winner;
                    mem_addr_d   = winner ? bus.req_addr1  : bus.req_addr0;
                    mem_wdata_d  = winner ? bus.req_wdata1 : bus.req_wdata0;
                    mem_we_d     = bus.req_we[winner];
                    mem_enable_d = 1'b1;
                    busy_d       = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = S_WAIT;
                end
            end

            S_WAIT: begin
                wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
                if (accept) begin
                    rdata_d             = bus.mem_data_out;
                    ack_d[last_grant_q] = 1'b1;
                    err_d               = 1'b0;
                    mem_enable_d        = 1'b0;
                    mem_we_d            = 1'b0;
                    state_d             = S_GAP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt_q == TMO_LAST) begin
                    rdata_d             = '0;
                    ack_d[last_grant_q] = 1'b1;
                    err_d               = 1'b1;
                    mem_enable_d        = 1'b0;
                    mem_we_d            = 1'b0;
                    state_d             = S_GAP;
                end
`endif
            end

            S_GAP: begin
                busy_d  = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                mem_enable_d = 1'b0;
                mem_we_d     = 1'b0;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_enable_q <= mem_enable_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.mem_enable  = mem_enable_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a DELAY=5 memory model holding mem[i]=i.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog path (TIMEOUT_CYCLES=20).
module tb_mem_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DELAY = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_LENGTH(AW), .BLOCK_SIZE(DW)) bus ();

    mem_arbiter #(
        .ADDR_LENGTH(AW),
        .BLOCK_SIZE(DW),
        .TIMEOUT_CYCLES(20),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Memory model: flag cleared on enable rise, set DELAY edges later, held until next rise.
    logic [DW-1:0] mem [1024];
    logic          mem_ready = 1'b0;
    logic          en_q = 1'b0;
    int            mcnt = 0;
    logic          m_complete = 1'b0;
    logic [DW-1:0] m_dout = '0;
    logic          mem_stuck = 1'b0;

    assign bus.mem_complete = m_complete;
    assign bus.mem_data_out = m_dout;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= DW'(i);
            mem_ready <= 1'b1;
        end
        if (!bus.mem_enable) begin
            en_q <= 1'b0;
        end else if (!en_q) begin
            en_q       <= 1'b1;
            mcnt       <= 0;
            m_complete <= 1'b0;
        end else if (!m_complete && !mem_stuck) begin
            if (mcnt == DELAY - 1) begin
                m_complete <= 1'b1;
                m_dout     <= mem[bus.mem_addr];
                if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data_in;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_enable"}, 32'(bus.mem_enable), 0);
        chk({tag, "_mem_we"},     32'(bus.mem_we), 0);
        chk({tag, "_mem_addr"},   32'(bus.mem_addr), 0);
        chk({tag, "_mem_data_in"}, bus.mem_data_in, 0);
        chk({tag, "_ack"},        32'(bus.ack), 0);
        chk({tag, "_rdata"},      bus.rdata, 0);
        chk({tag, "_err"},        32'(bus.err), 0);
        chk({tag, "_busy"},       32'(bus.busy), 0);
    endtask

    // Called at a negedge with the arbiter in IDLE; returns at the negedge after GAP.
    task automatic run(input string tag, input logic [1:0] rq, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input int port, input logic [DW-1:0] exp_rd,
                       input int exp_lat, input logic exp_err);
        int  lat;
        bit  got;
        lat = 0;
        got = 1'b0;
        bus.req = rq; bus.req_we = we;
        bus.req_addr0 = a0; bus.req_addr1 = a1;
        bus.req_wdata0 = w0; bus.req_wdata1 = w1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.ack != 2'b00) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
        bus.req = 2'b00;
        chk({tag, "_ack_seen"}, 32'(got), 1);
        if (got) begin
            chk({tag, "_ack"},     32'(bus.ack), 32'(1) << port);
            chk({tag, "_rdata"},   bus.rdata, exp_rd);
            chk({tag, "_err"},     32'(bus.err), 32'(exp_err));
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_busy_at_ack"}, 32'(bus.busy), 1);
            chk({tag, "_en_low1"}, 32'(bus.mem_enable), 0);
            @(negedge clk);
            chk({tag, "_ack_pulse"}, 32'(bus.ack), 0);
            chk({tag, "_busy_gap"},  32'(bus.busy), 0);
            chk({tag, "_en_low2"},   32'(bus.mem_enable), 0);
            chk({tag, "_rdata_hold"}, bus.rdata, exp_rd);
        end
    endtask

    typedef struct {
        string          tag;
        logic [1:0]     rq;
        logic [1:0]     we;
        logic [AW-1:0]  a0;
        logic [AW-1:0]  a1;
        logic [DW-1:0]  w0;
        logic [DW-1:0]  w1;
        int             port;
        logic [DW-1:0]  exp_rd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Grant edge to ack-visible edge is DELAY+2; seen at the (DELAY+3)th negedge.
        vecs[0]  = '{"rr0",    2'b11, 2'b00, 10'd3,   10'd7,   32'h0, 32'h0,      0, 32'd3};
        vecs[1]  = '{"rr1",    2'b11, 2'b00, 10'd3,   10'd7,   32'h0, 32'h0,      1, 32'd7};
        vecs[2]  = '{"rr2",    2'b11, 2'b00, 10'd3,   10'd7,   32'h0, 32'h0,      0, 32'd3};
        vecs[3]  = '{"rr3",    2'b11, 2'b00, 10'd3,   10'd7,   32'h0, 32'h0,      1, 32'd7};
        vecs[4]  = '{"rd10",   2'b01, 2'b00, 10'd10,  10'd0,   32'h0, 32'h0,      0, 32'd10};
        vecs[5]  = '{"rd50a",  2'b01, 2'b00, 10'd50,  10'd0,   32'h0, 32'h0,      0, 32'd50};
        vecs[6]  = '{"rd50b",  2'b01, 2'b00, 10'd50,  10'd0,   32'h0, 32'h0,      0, 32'd50};
        vecs[7]  = '{"wr50",   2'b10, 2'b10, 10'd0,   10'd50,  32'h0, 32'hDEAD,   1, 32'd50};
        vecs[8]  = '{"rdback", 2'b01, 2'b00, 10'd50,  10'd0,   32'h0, 32'h0,      0, 32'hDEAD};
        vecs[9]  = '{"rr4",    2'b11, 2'b00, 10'd100, 10'd200, 32'h0, 32'h0,      1, 32'd200};
        vecs[10] = '{"rd1_10", 2'b10, 2'b00, 10'd0,   10'd10,  32'h0, 32'h0,      1, 32'd10};

        bus.req = 2'b00; bus.req_we = 2'b00;
        bus.req_addr0 = '0; bus.req_addr1 = '0;
        bus.req_wdata0 = '0; bus.req_wdata1 = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_en",   32'(bus.mem_enable), 0);

        for (int i = 0; i < 11; i++)
            run(vecs[i].tag, vecs[i].rq, vecs[i].we, vecs[i].a0, vecs[i].a1,
                vecs[i].w0, vecs[i].w1, vecs[i].port, vecs[i].exp_rd, DELAY + 3, 1'b0);

        // Reset in the middle of WAIT, then a lone port-1 request.
        bus.req = 2'b01; bus.req_we = 2'b00; bus.req_addr0 = 10'd20;
        repeat (3) @(negedge clk);
        chk("midwait_en", 32'(bus.mem_enable), 1);
        chk("midwait_addr", 32'(bus.mem_addr), 20);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.req = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run("post_rst_p1", 2'b10, 2'b00, 10'd0, 10'd7, 32'h0, 32'h0, 1, 32'd7, DELAY + 3, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
        mem_stuck = 1'b1;
        run("timeout", 2'b01, 2'b00, 10'd5, 10'd0, 32'h0, 32'h0, 0, 32'd0, 21, 1'b1);
        mem_stuck = 1'b0;
        run("after_tmo", 2'b01, 2'b00, 10'd5, 10'd0, 32'h0, 32'h0, 0, 32'd5, DELAY + 3, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the shared fixed-latency main-memory block.
- Sits between the instruction-side and data-side cache miss paths and the single main-memory port.
- Serialises requests and drives the memory's level enable / address / write-enable / write-data.
- Waits for the memory's completion flag, returns read data with a one-cycle ack, and forces the enable-low gap the memory needs to restart its delay counter.

Parameters:
- ADDR_LENGTH, 10, memory word-address width (log2 of memory LENGTH).
- BLOCK_SIZE, 32, data word width.
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles. Used only with the optional feature.
- CNT_W, 8, wait-counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request level. Held high with its fields stable until the matching ack.
- req_we  in  2  per-requester write flag (1 = write, 0 = read).
- req_addr0, req_addr1  in  ADDR_LENGTH  per-requester word address.
- req_wdata0, req_wdata1  in  BLOCK_SIZE  per-requester write data.
- ack  out  2  one-cycle completion pulse to the granted requester.
- rdata  out  BLOCK_SIZE  memory data_out captured at completion. For a write this is the old value.
- err  out  1  high together with ack when the transaction timed out.
- busy  out  1  high from grant until the end of GAP.
- mem_enable  out  1  to memory enable.
- mem_we  out  1  to memory we.
- mem_addr  out  ADDR_LENGTH  to memory addr.
- mem_data_in  out  BLOCK_SIZE  to memory data_in.
- mem_data_out  in  BLOCK_SIZE  from memory data_out.
- mem_complete  in  1  from memory requestComplete.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - All outputs 0: mem_enable, mem_we, mem_addr, mem_data_in, ack, rdata, err, busy.
  - last_grant=1, so port 0 wins the first contention.
  - wait_cnt=0.
- All state changes occur on clk rising edge; all outputs are registered.
- IDLE:
  - If req != 0, pick the winner round-robin: the port other than last_grant if it requests, else the requesting port.
  - Latch winner's addr/we/wdata into mem_addr/mem_we/mem_data_in.
  - Set mem_enable=1, busy=1, last_grant=winner, wait_cnt=0. Go to WAIT.
  - Simultaneous req=2'b11 alternates grants strictly.
- WAIT:
  - mem_enable held 1; mem_addr/mem_we/mem_data_in stable.
  - wait_cnt increments each cycle, saturating at all-ones.
  - mem_complete is ignored while wait_cnt==0. The memory clears the flag only on the enable rising edge, so a stale flag from the prior access must not be accepted.
  - When mem_complete=1 and wait_cnt>=1:
    - rdata <= mem_data_out.
    - ack[winner] <= 1, err <= 0.
    - mem_enable <= 0, mem_we <= 0.
    - Go to GAP.
- GAP:
  - Lasts exactly one cycle: ack <= 0, mem_enable stays 0, busy <= 0. Go to IDLE.
  - Guarantees at least 2 cycles of enable low between accesses, so every access produces a fresh enable rising edge.
- Latency:
  - ack asserts 2 cycles after the memory asserts completion relative to grant edge, i.e. roughly memory DELAY+2 cycles after req is seen in IDLE.
  - Back-to-back throughput: one access per DELAY+4 cycles.
- Requester drops req mid-transaction: the access still completes, memory is written if we=1, and ack still pulses. The requester ignores it.
- New req arriving during WAIT/GAP is not sampled until IDLE.
- Reset mid-transaction: immediate return to reset values. mem_enable falls; the memory's partial access is abandoned.
- rdata holds its value until the next completion.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With macro defined:
  - In WAIT, if wait_cnt reaches TIMEOUT_CYCLES without an accepted mem_complete, pulse ack[winner]=1 with err=1 and rdata <= 0.
  - mem_enable <= 0, then GAP → IDLE as normal.
  - A write that times out is reported as failed. Whether memory committed it is undefined.
- Without macro:
  - err is tied 0 and TIMEOUT_CYCLES is unused.
  - WAIT persists until mem_complete.

Test Plan:
- Memory DELAY=5, mem[i]=i. Reset, then req=2'b01, req_addr0=10, req_we0=0 → one ack[0] pulse, rdata=10, err=0; mem_enable low 2+ cycles afterwards.
- req=2'b11 held, addr0=3, addr1=7, reads → grants alternate 0,1,0,1. rdata sequence 3,7,3,7. Never two acks in the same cycle.
- Write port 1: addr1=50, wdata1=0xDEAD, we=1 → ack[1] with rdata=50 (old). Then read addr0=50 → rdata=0xDEAD.
- Two consecutive reads to the same address 50 → second access waits the full DELAY; stale mem_complete is not accepted in WAIT's first cycle; rdata=50.
- reset_n low for 1 cycle mid-WAIT → all outputs 0 asynchronously. A subsequent req=2'b10 is granted to port 1, since last_grant=1 means port 0 is preferred only on contention.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20, memory completion stuck 0 → ack[0] and err=1 on the 20th WAIT cycle, rdata=0, busy falls 1 cycle later.
